// File: rtl/dram_pkg.sv
// Shared geometry defaults and sequencer state encoding for the 8-bank DRAM command path.
package dram_pkg;

  localparam int DRAM_NUM_OF_BANKS = 8;
  localparam int DRAM_NUM_OF_ROWS  = 128;
  localparam int DRAM_NUM_OF_COLS  = 8;
  localparam int DRAM_ACT_CYCLES   = 2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    ACT,
    RD_ISSUE,
    RD_CAPTURE,
    RESP
  } state_t;

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank record of which row currently sits in that bank's row buffer.
module dram_open_row_table
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = DRAM_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DRAM_NUM_OF_ROWS,
  localparam int BW = $clog2(NUM_OF_BANKS),
  localparam int RW = $clog2(NUM_OF_ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] i_lookupBank,
  input  logic [RW-1:0] i_lookupRow,
  output logic          o_hit,
  input  logic          i_setEn,
  input  logic [BW-1:0] i_setBank,
  input  logic [RW-1:0] i_setRow,
  input  logic          i_invEn,
  input  logic [BW-1:0] i_invBank,
  input  logic [RW-1:0] i_invRow
);

  logic [NUM_OF_BANKS-1:0] r_valid;
  logic [RW-1:0]           r_row [NUM_OF_BANKS];
  logic                    w_invMatch;

  assign o_hit      = r_valid[i_lookupBank] && (r_row[i_lookupBank] == i_lookupRow);
  assign w_invMatch = r_valid[i_invBank] && (r_row[i_invBank] == i_invRow);

  // A write only stales the buffer when it targets the row that is held open.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) r_row[i] <= '0;
    end else begin
      if (i_setEn) begin
        r_valid[i_setBank] <= 1'b1;
        r_row[i_setBank]   <= i_setRow;
      end
      if (i_invEn && w_invMatch) r_valid[i_invBank] <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Single-requester command sequencer: turns host read/write requests into DRAM model strobes,
// skipping the row load when the target row is already open in that bank.
module dram_cmd_sequencer
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = DRAM_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DRAM_NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = DRAM_NUM_OF_COLS,
  parameter int ACT_CYCLES   = DRAM_ACT_CYCLES,
  localparam int BW = $clog2(NUM_OF_BANKS),
  localparam int RW = $clog2(NUM_OF_ROWS),
  localparam int CW = $clog2(NUM_OF_COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [BW-1:0] req_bank,
  input  logic [RW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  input  logic          req_wdata,
  output logic          rsp_valid,
  output logic          rsp_rdata,
  output logic          dram_bank_rw,
  output logic          dram_buf_rw,
  output logic [BW-1:0] dram_bank_id,
  output logic [RW-1:0] dram_rowid,
  output logic [CW-1:0] dram_colid,
  inout  wire           dram_data
);

  localparam int CNTW = $clog2(ACT_CYCLES + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CNTW-1:0] r_actCnt;
  logic            r_ready, r_rspValid, r_rdata, r_bankRw, r_bufRw, r_wdata;
  logic [BW-1:0]   r_bank;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            w_accept, w_hit, w_actDone;

  assign w_accept  = req_valid && r_ready;
  assign w_actDone = (r_state == ACT) && (r_actCnt == CNTW'(ACT_CYCLES - 1));

  dram_open_row_table #(
    .NUM_OF_BANKS (NUM_OF_BANKS),
    .NUM_OF_ROWS  (NUM_OF_ROWS)
  ) u_openRows (
    .clk          (clk),
    .rst          (rst),
    .i_lookupBank (req_bank),
    .i_lookupRow  (req_row),
    .o_hit        (w_hit),
    .i_setEn      (w_actDone),
    .i_setBank    (r_bank),
    .i_setRow     (r_row),
    .i_invEn      (w_accept && req_we),
    .i_invBank    (req_bank),
    .i_invRow     (req_row)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_accept) w_next = req_we ? WRITE : (w_hit ? RD_ISSUE : ACT);
      WRITE:      w_next = RESP;
      ACT:        if (w_actDone) w_next = RD_ISSUE;
      RD_ISSUE:   w_next = RD_CAPTURE;
      RD_CAPTURE: w_next = RESP;
      RESP:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_actCnt   <= '0;
      r_ready    <= 1'b1;
      r_rspValid <= 1'b0;
      r_rdata    <= 1'b0;
      r_bankRw   <= 1'b0;
      r_bufRw    <= 1'b0;
      r_wdata    <= 1'b0;
      r_bank     <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      r_state    <= w_next;
      r_ready    <= (w_next == IDLE);
      r_rspValid <= (w_next == RESP);
      r_bankRw   <= (w_next == WRITE);
      r_bufRw    <= (w_next == WRITE) || (w_next == ACT);
      r_actCnt   <= (r_state == ACT) ? r_actCnt + 1'b1 : '0;
      if (w_accept) begin
        r_bank  <= req_bank;
        r_row   <= req_row;
        r_col   <= req_col;
        r_wdata <= req_wdata;
        r_rdata <= 1'b0;
      end
      if (r_state == RD_CAPTURE) r_rdata <= dram_data;
    end
  end

  assign req_ready    = r_ready;
  assign rsp_valid    = r_rspValid;
  assign rsp_rdata    = r_rdata;
  assign dram_bank_rw = r_bankRw;
  assign dram_buf_rw  = r_bufRw;
  assign dram_bank_id = r_bank;
  assign dram_rowid   = r_row;
  assign dram_colid   = r_col;
  assign dram_data    = r_bankRw ? r_wdata : 1'bz;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Bench for dram_cmd_sequencer: behavioural DRAM array model on the pins, plus an abstract
// reference of memory contents and open rows that predicts latency, row loads and read data.
module tb_dram_cmd_sequencer;

  localparam int NB  = 8;
  localparam int NR  = 128;
  localparam int NC  = 8;
  localparam int ACT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [2:0] req_bank = '0;
  logic [6:0] req_row = '0;
  logic [2:0] req_col = '0;
  logic       req_wdata = 1'b0;
  logic       rsp_valid, rsp_rdata;
  logic       dram_bank_rw, dram_buf_rw;
  logic [2:0] dram_bank_id;
  logic [6:0] dram_rowid;
  logic [2:0] dram_colid;
  wire        dram_data;

  int vectors = 0;
  int miscompares = 0;
  int contention = 0;

  always #5 clk = ~clk;

  dram_cmd_sequencer #(
    .NUM_OF_BANKS (NB),
    .NUM_OF_ROWS  (NR),
    .NUM_OF_COLS  (NC),
    .ACT_CYCLES   (ACT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_bank     (req_bank),
    .req_row      (req_row),
    .req_col      (req_col),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .dram_bank_rw (dram_bank_rw),
    .dram_buf_rw  (dram_buf_rw),
    .dram_bank_id (dram_bank_id),
    .dram_rowid   (dram_rowid),
    .dram_colid   (dram_colid),
    .dram_data    (dram_data)
  );

  // DRAM pin model: array write on bank_rw, row buffer load on buf_rw, registered data out
  // driven onto the pin whenever buf_rw is low.
  logic tbMem  [NB][NR][NC] = '{default: 1'b0};
  logic rowBuf [NB][NC]     = '{default: 1'b0};
  logic dOut = 1'b0;

  always @(posedge clk) begin
    if (dram_bank_rw) tbMem[dram_bank_id][dram_rowid][dram_colid] <= dram_data;
    else if (dram_buf_rw)
      for (int i = 0; i < NC; i++) rowBuf[dram_bank_id][i] <= tbMem[dram_bank_id][dram_rowid][i];
    dOut <= rowBuf[dram_bank_id][dram_colid];
  end

  assign dram_data = dram_buf_rw ? 1'bz : dOut;

  // The sequencer drives the pin on bank_rw; the model drives whenever buf_rw is low.
  always @(negedge clk) if (dram_bank_rw && !dram_buf_rw) contention++;

  // Reference: what each address holds and which row each bank has open.
  logic       refMem [NB][NR][NC] = '{default: 1'b0};
  logic       refV   [NB]         = '{default: 1'b0};
  logic [6:0] refRow [NB]         = '{default: 7'd0};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic predict(input logic we, input logic [2:0] b, input logic [6:0] r,
                         input logic [2:0] c, input logic wd,
                         output int lat, output int bufc, output logic d);
    if (we) begin
      lat  = 2;
      bufc = 1;
      d    = 1'b0;
      if (refV[b] && refRow[b] == r) refV[b] = 1'b0;
      refMem[b][r][c] = wd;
    end else begin
      if (refV[b] && refRow[b] == r) begin
        lat  = 3;
        bufc = 0;
      end else begin
        lat       = 3 + ACT;
        bufc      = ACT;
        refV[b]   = 1'b1;
        refRow[b] = r;
      end
      d = refMem[b][r][c];
    end
  endtask

  task automatic clearOpenRows();
    for (int i = 0; i < NB; i++) refV[i] = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ready"},  32'(req_ready), 32'd1);
    checkOutput({tag, "_rspv"},   32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rdata"},  32'(rsp_rdata), 32'd0);
    checkOutput({tag, "_bankrw"}, 32'(dram_bank_rw), 32'd0);
    checkOutput({tag, "_bufrw"},  32'(dram_buf_rw), 32'd0);
    checkOutput({tag, "_bank"},   32'(dram_bank_id), 32'd0);
    checkOutput({tag, "_row"},    32'(dram_rowid), 32'd0);
    checkOutput({tag, "_col"},    32'(dram_colid), 32'd0);
  endtask

  // One request from accept to response, with latency, row-load count and read data checked.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] b,
                               input logic [6:0] r, input logic [2:0] c, input logic wd);
    int   expLat, expBuf, lat, bufCnt, guard;
    logic expData;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    predict(we, b, r, c, wd, expLat, expBuf, expData);
    req_we    = we;
    req_bank  = b;
    req_row   = r;
    req_col   = c;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat       = 1;
    bufCnt    = 0;
    checkOutput({tag, "_busy"}, 32'(req_ready), 32'd0);
    while (!rsp_valid && lat < 20) begin
      if (dram_buf_rw) bufCnt++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_lat"},   32'(lat), 32'(expLat));
    checkOutput({tag, "_loads"}, 32'(bufCnt), 32'(expBuf));
    checkOutput({tag, "_rdata"}, 32'(rsp_rdata), 32'(expData));
  endtask

  logic [2:0] wB [4] = '{3'd0, 3'd1, 3'd6, 3'd1};
  logic [6:0] wR [4] = '{7'd1, 7'd9, 7'd100, 7'd9};
  logic [2:0] wC [4] = '{3'd3, 3'd0, 3'd7, 3'd0};
  logic       wD [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int         k, cyc, rspCnt, overlap, dLat, dBuf;
    int         accCyc [4];
    logic       dData;
    logic [31:0] rnd;

    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Miss after write, hit on untouched column, write-invalidate, per-bank tracking.
    applyStimulus("t1_wr",   1'b1, 3'd3, 7'd5, 3'd2, 1'b1);
    applyStimulus("t1_rd",   1'b0, 3'd3, 7'd5, 3'd2, 1'b0);
    applyStimulus("t2_rd",   1'b0, 3'd3, 7'd5, 3'd7, 1'b0);
    applyStimulus("t3_wr",   1'b1, 3'd3, 7'd5, 3'd7, 1'b1);
    applyStimulus("t3_rd",   1'b0, 3'd3, 7'd5, 3'd7, 1'b0);
    applyStimulus("t4_ld0",  1'b0, 3'd0, 7'd1, 3'd0, 1'b0);
    applyStimulus("t4_ld1",  1'b0, 3'd1, 7'd9, 3'd0, 1'b0);
    applyStimulus("t4_hit0", 1'b0, 3'd0, 7'd1, 3'd4, 1'b0);
    applyStimulus("t4_hit1", 1'b0, 3'd1, 7'd9, 3'd5, 1'b0);

    // Valid held high across four writes; fields scrambled whenever ready is low.
    rnd       = $urandom;
    req_we    = rnd[13];
    req_bank  = rnd[2:0];
    req_row   = rnd[9:3];
    req_col   = rnd[12:10];
    req_wdata = rnd[14];
    req_valid = 1'b1;
    k = 0; cyc = 0; rspCnt = 0; overlap = 0;
    while ((k < 4 || rspCnt < 4) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) rspCnt++;
      if (rsp_valid && req_ready) overlap++;
      if (k == 4) begin
        req_valid = 1'b0;
      end else if (req_ready) begin
        req_we    = 1'b1;
        req_bank  = wB[k];
        req_row   = wR[k];
        req_col   = wC[k];
        req_wdata = wD[k];
        predict(1'b1, wB[k], wR[k], wC[k], wD[k], dLat, dBuf, dData);
        accCyc[k] = cyc;
        k++;
      end else begin
        rnd       = $urandom;
        req_we    = rnd[13];
        req_bank  = rnd[2:0];
        req_row   = rnd[9:3];
        req_col   = rnd[12:10];
        req_wdata = rnd[14];
      end
    end
    req_valid = 1'b0;
    checkOutput("t6_accepts", 32'(k), 32'd4);
    checkOutput("t6_rsps", 32'(rspCnt), 32'd4);
    checkOutput("t6_overlap", 32'(overlap), 32'd0);
    for (int i = 1; i < 4; i++) checkOutput("t6_period", 32'(accCyc[i] - accCyc[i-1]), 32'd3);
    applyStimulus("t6_rb0", 1'b0, 3'd0, 7'd1,   3'd3, 1'b0);
    applyStimulus("t6_rb1", 1'b0, 3'd1, 7'd9,   3'd0, 1'b0);
    applyStimulus("t6_rb2", 1'b0, 3'd6, 7'd100, 3'd7, 1'b0);

    // Reset during the second row-load cycle of a miss.
    while (!req_ready) @(negedge clk);
    req_we    = 1'b0;
    req_bank  = 3'd2;
    req_row   = 7'd4;
    req_col   = 3'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("t5_act1", 32'(dram_buf_rw), 32'd1);
    @(negedge clk);
    checkOutput("t5_act2", 32'(dram_buf_rw), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset("t5");
    clearOpenRows();
    applyStimulus("t5_reread", 1'b0, 3'd2, 7'd4, 3'd0, 1'b0);
    applyStimulus("t5_oldopen", 1'b0, 3'd3, 7'd5, 3'd2, 1'b0);

    // Random traffic over a few rows per bank so hits, misses and invalidations all occur.
    for (int n = 0; n < 40; n++) begin
      rnd = $urandom;
      applyStimulus("rand", rnd[13], rnd[2:0], {5'd0, rnd[4:3]}, rnd[12:10], rnd[14]);
    end

    checkOutput("no_contention", 32'(contention), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
